// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for one shared combinational alu.
// Results are captured into a one-entry buffer and returned on a tagged response channel.
module alu_share_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_NUM     = 12,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_NUM-1:0]     req0_op,
  input  logic [DATA_WIDTH-1:0] req0_src1,
  input  logic [DATA_WIDTH-1:0] req0_src2,
  input  logic [TAG_WIDTH-1:0]  req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_NUM-1:0]     req1_op,
  input  logic [DATA_WIDTH-1:0] req1_src1,
  input  logic [DATA_WIDTH-1:0] req1_src2,
  input  logic [TAG_WIDTH-1:0]  req1_tag,
  output logic [OP_NUM-1:0]     alu_op,
  output logic [DATA_WIDTH-1:0] alu_src1,
  output logic [DATA_WIDTH-1:0] alu_src2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_id,
  output logic                  rsp_err
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ptr;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_rsp_id;
  logic                  r_rsp_err;

  logic                  w_can_accept;
  logic                  w_grant;
  logic                  w_gnt_id;
  logic                  w_onehot;
  logic [OP_NUM-1:0]     w_gnt_op;
  logic [DATA_WIDTH-1:0] w_gnt_src1;
  logic [DATA_WIDTH-1:0] w_gnt_src2;
  logic [TAG_WIDTH-1:0]  w_gnt_tag;

  // A full buffer can still accept when its entry drains this same cycle.
  assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;

  always_comb begin
    w_gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = r_ptr;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  assign w_grant    = (req0_valid | req1_valid) & w_can_accept;
  assign req0_ready = w_grant & ~w_gnt_id;
  assign req1_ready = w_grant & w_gnt_id;

  assign w_gnt_op   = w_gnt_id ? req1_op   : req0_op;
  assign w_gnt_src1 = w_gnt_id ? req1_src1 : req0_src1;
  assign w_gnt_src2 = w_gnt_id ? req1_src2 : req0_src2;
  assign w_gnt_tag  = w_gnt_id ? req1_tag  : req0_tag;

  assign w_onehot = (w_gnt_op != '0) && ((w_gnt_op & (w_gnt_op - OP_NUM'(1))) == '0);

  // Alu inputs stay at zero whenever nothing is granted.
  assign alu_op   = w_grant ? w_gnt_op   : '0;
  assign alu_src1 = w_grant ? w_gnt_src1 : '0;
  assign alu_src2 = w_grant ? w_gnt_src2 : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_grant) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr <= ~w_gnt_id;
      end
    end
  end

  // Malformed ops are accepted but flagged, and the alu output is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (w_grant) begin
      r_rsp_result <= w_onehot ? alu_result : '0;
      r_rsp_tag    <= w_gnt_tag;
      r_rsp_id     <= w_gnt_id;
      r_rsp_err    <= ~w_onehot;
    end
  end

  assign rsp_valid  = (r_state == ST_FULL);
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_id     = r_rsp_id;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: behavioural alu, response scoreboard,
// and per-scenario tasks checking arbitration, backpressure, errors and reset.
module tb_alu_share_arb;

  logic        clk;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [11:0] req0_op, req1_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_tag, req1_tag;
  logic [11:0] alu_op;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_id, rsp_err;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_ptr = 1'b0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        id;
    logic        err;
  } exp_t;
  exp_t sb[$];

  alu_share_arb #(.DATA_WIDTH(32), .OP_NUM(12), .TAG_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  // Behavioural alu; malformed ops give a recognisable junk value.
  function automatic logic [31:0] alu_model(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    if ($countones(op) != 1) return 32'hDEAD_BEEF;
    case (1'b1)
      op[0]:  return a + b;
      op[1]:  return a - b;
      op[2]:  return {31'd0, $signed(a) < $signed(b)};
      op[3]:  return {31'd0, a < b};
      op[4]:  return a & b;
      op[5]:  return ~(a | b);
      op[6]:  return a | b;
      op[7]:  return a ^ b;
      op[8]:  return a << b[4:0];
      op[9]:  return a >> b[4:0];
      op[10]: return 32'($signed(a) >>> b[4:0]);
      default: return {b[19:0], 12'd0};
    endcase
  endfunction

  function automatic exp_t expect_of(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] tag, input logic id);
    exp_t e;
    e.err = ($countones(op) != 1);
    e.res = e.err ? 32'd0 : alu_model(op, a, b);
    e.tag = tag;
    e.id  = id;
    return e;
  endfunction

  assign alu_result = alu_model(alu_op, alu_src1, alu_src2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push on accepted request, pop on consumed response.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: response res=%h tag=%h id=%0d with nothing expected", rsp_result, rsp_tag, rsp_id);
        end else begin
          e = sb.pop_front();
          if ({rsp_result, rsp_tag, rsp_id, rsp_err} !== e) begin
            n_err++;
            $display("FAIL sb_rsp: got res=%h tag=%h id=%0d err=%0d, want res=%h tag=%h id=%0d err=%0d",
                     rsp_result, rsp_tag, rsp_id, rsp_err, e.res, e.tag, e.id, e.err);
          end
        end
      end
      if (req0_ready) sb.push_back(expect_of(req0_op, req0_src1, req0_src2, req0_tag, 1'b0));
      if (req1_ready) sb.push_back(expect_of(req1_op, req1_src1, req1_src2, req1_tag, 1'b1));
    end
  end

  always @(negedge resetn) sb.delete();

  task automatic set_req0(input logic v, input logic [11:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req0_valid = v; req0_op = op; req0_src1 = a; req0_src2 = b; req0_tag = t;
  endtask

  task automatic set_req1(input logic v, input logic [11:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req1_valid = v; req1_op = op; req1_src1 = a; req1_src2 = b; req1_tag = t;
  endtask

  task automatic next_drive();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rsp_ready = 1'b0;
    set_req0(1'b0, '0, '0, '0, '0);
    set_req1(1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_tag, rsp_id, rsp_err} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_rsp: got v=%0d res=%h tag=%h id=%0d err=%0d, want all 0", rsp_valid, rsp_result, rsp_tag, rsp_id, rsp_err);
    end
    n_cmp++;
    if (alu_op !== 12'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got alu_op=%h r0=%0d r1=%0d, want 0 0 0", alu_op, req0_ready, req1_ready);
    end
    #2 resetn = 1'b1;
    exp_ptr = 1'b0;
  endtask

  task automatic test_single();
    next_drive();
    rsp_ready = 1'b1;
    set_req0(1'b1, 12'h001, 32'd5, 32'd7, 4'd3);
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || alu_op !== 12'h001 || alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin
      n_err++;
      $display("FAIL single_grant: got r0=%0d r1=%0d op=%h s1=%0d s2=%0d, want 1 0 001 5 7", req0_ready, req1_ready, alu_op, alu_src1, alu_src2);
    end
    next_drive();
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_tag !== 4'd3 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL single_rsp: got v=%0d res=%0d tag=%0d id=%0d err=%0d, want 1 12 3 0 0", rsp_valid, rsp_result, rsp_tag, rsp_id, rsp_err);
    end
    n_cmp++;
    if (alu_op !== 12'd0 || alu_src1 !== 32'd0) begin
      n_err++;
      $display("FAIL quiet_alu: got op=%h s1=%h, want 0 0", alu_op, alu_src1);
    end
    next_drive();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: got rsp_valid=%0d want 0", rsp_valid);
    end
    exp_ptr = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] op0 [3] = '{12'h002, 12'h010, 12'h080};
    logic [31:0] a0  [3] = '{32'd10, 32'hFF, 32'hAA};
    logic [31:0] b0  [3] = '{32'd3, 32'h0F, 32'hFF};
    logic [31:0] r0  [3] = '{32'd7, 32'h0F, 32'h55};
    logic [11:0] op1 [3] = '{12'h040, 12'h001, 12'h100};
    logic [31:0] a1  [3] = '{32'hF0, 32'd100, 32'd1};
    logic [31:0] b1  [3] = '{32'h0F, 32'd23, 32'd4};
    logic [31:0] r1  [3] = '{32'hFF, 32'd123, 32'd16};
    int i0 = 0;
    int i1 = 0;
    logic g;
    logic prev_id = 1'b0;
    logic [31:0] prev_res = '0;
    next_drive();
    set_req0(1'b1, op0[0], a0[0], b0[0], 4'd0);
    set_req1(1'b1, op1[0], a1[0], b1[0], 4'd8);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g = exp_ptr;
      n_cmp++;
      if (req0_ready !== ~g || req1_ready !== g) begin
        n_err++;
        $display("FAIL b2b_grant[%0d]: got r0=%0d r1=%0d, want r0=%0d r1=%0d", k, req0_ready, req1_ready, ~g, g);
      end
      if (k > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_result !== prev_res || rsp_id !== prev_id) begin
          n_err++;
          $display("FAIL b2b_rsp[%0d]: got v=%0d res=%h id=%0d, want 1 %h %0d", k, rsp_valid, rsp_result, rsp_id, prev_res, prev_id);
        end
      end
      prev_id  = g;
      prev_res = g ? r1[i1] : r0[i0];
      exp_ptr  = ~g;
      next_drive();
      if (g) begin
        i1++;
        if (i1 < 3) set_req1(1'b1, op1[i1], a1[i1], b1[i1], 4'(8 + i1));
        else req1_valid = 1'b0;
      end else begin
        i0++;
        if (i0 < 3) set_req0(1'b1, op0[i0], a0[i0], b0[i0], 4'(i0));
        else req0_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_result !== prev_res || rsp_id !== prev_id) begin
      n_err++;
      $display("FAIL b2b_last: got v=%0d res=%h id=%0d, want 1 %h %0d", rsp_valid, rsp_result, rsp_id, prev_res, prev_id);
    end
    next_drive();
  endtask

  task automatic test_backpressure();
    next_drive();
    rsp_ready = 1'b1;
    set_req0(1'b1, 12'h001, 32'd1000, 32'd24, 4'd4);
    set_req1(1'b1, 12'h080, 32'h1234, 32'h00FF, 4'd5);
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_first: got r0=%0d r1=%0d, want 0 1", req0_ready, req1_ready);
    end
    next_drive();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_op !== 12'd0 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got r0=%0d r1=%0d op=%h s1=%h s2=%h, want all 0", k, req0_ready, req1_ready, alu_op, alu_src1, alu_src2);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h12CB || rsp_tag !== 4'd5 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%0d res=%h tag=%0d id=%0d err=%0d, want 1 12cb 5 1 0", k, rsp_valid, rsp_result, rsp_tag, rsp_id, rsp_err);
      end
      next_drive();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got r0=%0d r1=%0d v=%0d, want 1 0 1", req0_ready, req1_ready, rsp_valid);
    end
    next_drive();
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_result !== 32'd1024 || rsp_id !== 1'b0) begin
      n_err++;
      $display("FAIL bp_after: got r1=%0d v=%0d res=%0d id=%0d, want 1 1 1024 0", req1_ready, rsp_valid, rsp_result, rsp_id);
    end
    next_drive();
    req1_valid = 1'b0;
    next_drive();
    exp_ptr = 1'b0;
  endtask

  task automatic test_error_op();
    set_req1(1'b1, 12'h003, 32'd5, 32'd6, 4'd9);
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL err_accept: got r1=%0d want 1", req1_ready);
    end
    next_drive();
    set_req1(1'b1, 12'h000, 32'd7, 32'd8, 4'd10);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_id !== 1'b1 || rsp_tag !== 4'd9) begin
      n_err++;
      $display("FAIL err_multi: got v=%0d err=%0d res=%h id=%0d tag=%0d, want 1 1 0 1 9", rsp_valid, rsp_err, rsp_result, rsp_id, rsp_tag);
    end
    next_drive();
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_tag !== 4'd10) begin
      n_err++;
      $display("FAIL err_zero: got v=%0d err=%0d res=%h tag=%0d, want 1 1 0 10", rsp_valid, rsp_err, rsp_result, rsp_tag);
    end
    next_drive();
  endtask

  task automatic test_pointer_hold();
    for (int k = 0; k < 2; k++) begin
      set_req1(1'b1, 12'h001, 32'(k), 32'd1, 4'(k + 1));
      @(negedge clk);
      n_cmp++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ptr_solo[%0d]: got r0=%0d r1=%0d, want 0 1", k, req0_ready, req1_ready);
      end
      next_drive();
    end
    req1_valid = 1'b0;
    next_drive();
    set_req0(1'b1, 12'h010, 32'hF0F0, 32'h0FF0, 4'd6);
    set_req1(1'b1, 12'h040, 32'h1, 32'h2, 4'd7);
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ptr_dual: got r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
    end
    next_drive();
    req0_valid = 1'b0;
    next_drive();
    req1_valid = 1'b0;
    next_drive();
  endtask

  task automatic test_async_reset();
    set_req0(1'b1, 12'h001, 32'd2, 32'd3, 4'd11);
    next_drive();
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_full: got rsp_valid=%0d want 1", rsp_valid);
    end
    #1 resetn = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_tag !== 4'd0) begin
      n_err++;
      $display("FAIL arst_clear: got v=%0d res=%h tag=%0d, want 0 0 0", rsp_valid, rsp_result, rsp_tag);
    end
    #1 resetn = 1'b1;
    exp_ptr = 1'b0;
    next_drive();
    rsp_ready = 1'b1;
    set_req0(1'b1, 12'h002, 32'd9, 32'd4, 4'd12);
    set_req1(1'b1, 12'h001, 32'd9, 32'd4, 4'd13);
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL arst_ptr: got r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
    end
    next_drive();
    req0_valid = 1'b0;
    next_drive();
    req1_valid = 1'b0;
    repeat (2) next_drive();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_error_op();
    test_pointer_hold();
    test_async_reset();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
